// File: rtl/system_dual_port_ram.sv
// True dual-port RAM: s1 is a read-only fetch port, s2 is a byte-enabled read/write data port.
// Read latency is 1 or 2 advancing cycles; a same-address s2 write is forwarded into a concurrent s1 read.
module system_dual_port_ram #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 16,
  parameter int    DEPTH      = 40000,
  parameter int    OUT_REG    = 0,
  parameter string INIT_FILE  = "../code/demo/bin/demo.mif"
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reset_req,
  input  logic                      clken,
  input  logic [ADDR_WIDTH-1:0]     s1_address,
  input  logic                      s1_read,
  output logic [DATA_WIDTH-1:0]     s1_readdata,
  output logic                      s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]     s2_address,
  input  logic                      s2_chipselect,
  input  logic                      s2_read,
  input  logic                      s2_write,
  input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
  input  logic [DATA_WIDTH-1:0]     s2_writedata,
  output logic [DATA_WIDTH-1:0]     s2_readdata,
  output logic                      s2_readdatavalid,
  output logic                      range_err
);

  localparam int Lanes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  en;
  logic                  s1Acc;
  logic                  s2WrAcc;
  logic                  s2RdAcc;
  logic                  s1InRange;
  logic                  s2InRange;
  logic                  s2WrOk;
  logic                  collide;
  logic [DATA_WIDTH-1:0] s1Word;
  logic [DATA_WIDTH-1:0] s2Word;
  logic [DATA_WIDTH-1:0] s1Data_d;
  logic [DATA_WIDTH-1:0] s2Data_d;
  logic                  rdErr_d;
  logic                  wrErr_d;

  logic                  s1Valid1_q;
  logic [DATA_WIDTH-1:0] s1Data1_q;
  logic                  s2Valid1_q;
  logic [DATA_WIDTH-1:0] s2Data1_q;
  logic                  rdErr1_q;
  logic                  wrErr1_q;

  logic                  rdErrOut;

  // Request decode; write wins over read on s2, out-of-range reads return zero.
  always_comb begin
    en        = clken & ~reset_req;
    s1Acc     = en & s1_read;
    s2WrAcc   = en & s2_chipselect & s2_write;
    s2RdAcc   = en & s2_chipselect & s2_read & ~s2_write;
    s1InRange = {1'b0, s1_address} < DepthW;
    s2InRange = {1'b0, s2_address} < DepthW;
    s2WrOk    = s2WrAcc & s2InRange;
    collide   = s1Acc & s2WrOk & (s1_address == s2_address);

    s1Word = '0;
    if (s1InRange) begin
      s1Word = mem[s1_address];
    end
    s2Word = '0;
    if (s2InRange) begin
      s2Word = mem[s2_address];
    end

    s1Data_d = s1Word;
    if (collide) begin
      for (int i = 0; i < Lanes; i++) begin
        if (s2_byteenable[i]) begin
          s1Data_d[8*i +: 8] = s2_writedata[8*i +: 8];
        end
      end
    end
    s2Data_d = s2Word;

    rdErr_d = (s1Acc & ~s1InRange) | (s2RdAcc & ~s2InRange);
    wrErr_d = s2WrAcc & ~s2InRange;
  end

  always_ff @(posedge clk) begin
    if (!reset && s2WrOk) begin
      for (int i = 0; i < Lanes; i++) begin
        if (s2_byteenable[i]) begin
          mem[s2_address][8*i +: 8] <= s2_writedata[8*i +: 8];
        end
      end
    end
  end

  // First read stage; data registers only move on an accepted read so they hold the last valid word.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid1_q <= 1'b0;
      s1Data1_q  <= '0;
      s2Valid1_q <= 1'b0;
      s2Data1_q  <= '0;
      rdErr1_q   <= 1'b0;
      wrErr1_q   <= 1'b0;
    end else if (en) begin
      s1Valid1_q <= s1Acc;
      s2Valid1_q <= s2RdAcc;
      rdErr1_q   <= rdErr_d;
      wrErr1_q   <= wrErr_d;
      if (s1Acc) begin
        s1Data1_q <= s1Data_d;
      end
      if (s2RdAcc) begin
        s2Data1_q <= s2Data_d;
      end
    end
  end

  if (OUT_REG != 0) begin : g_outReg
    logic                  s1Valid2_q;
    logic [DATA_WIDTH-1:0] s1Data2_q;
    logic                  s2Valid2_q;
    logic [DATA_WIDTH-1:0] s2Data2_q;
    logic                  rdErr2_q;

    // Read errors travel with their read; write errors still report one cycle after the write.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1Valid2_q <= 1'b0;
        s1Data2_q  <= '0;
        s2Valid2_q <= 1'b0;
        s2Data2_q  <= '0;
        rdErr2_q   <= 1'b0;
      end else if (en) begin
        s1Valid2_q <= s1Valid1_q;
        s2Valid2_q <= s2Valid1_q;
        rdErr2_q   <= rdErr1_q;
        if (s1Valid1_q) begin
          s1Data2_q <= s1Data1_q;
        end
        if (s2Valid1_q) begin
          s2Data2_q <= s2Data1_q;
        end
      end
    end

    assign s1_readdatavalid = s1Valid2_q;
    assign s1_readdata      = s1Data2_q;
    assign s2_readdatavalid = s2Valid2_q;
    assign s2_readdata      = s2Data2_q;
    assign rdErrOut         = rdErr2_q;
  end else begin : g_noOutReg
    assign s1_readdatavalid = s1Valid1_q;
    assign s1_readdata      = s1Data1_q;
    assign s2_readdatavalid = s2Valid1_q;
    assign s2_readdata      = s2Data1_q;
    assign rdErrOut         = rdErr1_q;
  end

  assign range_err = rdErrOut | wrErr1_q;

endmodule

// File: tb/tb_system_dual_port_ram.sv
// Directed bench for system_dual_port_ram: byte lanes, collision forwarding, range errors,
// clock-enable freeze and reset discard, checked with immediate assertions.
module tb_system_dual_port_ram;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int DEP = 40000;
  localparam int OREG = 0;
  localparam int LAT = (OREG != 0) ? 2 : 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          reset_req;
  logic          clken;
  logic [AW-1:0] s1_address;
  logic          s1_read;
  logic [DW-1:0] s1_readdata;
  logic          s1_readdatavalid;
  logic [AW-1:0] s2_address;
  logic          s2_chipselect;
  logic          s2_read;
  logic          s2_write;
  logic [3:0]    s2_byteenable;
  logic [DW-1:0] s2_writedata;
  logic [DW-1:0] s2_readdata;
  logic          s2_readdatavalid;
  logic          range_err;

  int checks = 0;
  int errors = 0;

  system_dual_port_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .OUT_REG(OREG), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_read(s1_read),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_read       = 1'b0;
    s2_chipselect = 1'b0;
    s2_read       = 1'b0;
    s2_write      = 1'b0;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [3:0] be);
    s2_address    = addr;
    s2_writedata  = data;
    s2_byteenable = be;
    s2_chipselect = 1'b1;
    s2_write      = 1'b1;
    cycle();
    idle();
  endtask

  task automatic readS1(input logic [AW-1:0] addr);
    s1_address = addr;
    s1_read    = 1'b1;
    cycle();
    idle();
    repeat (LAT - 1) cycle();
  endtask

  task automatic readS2(input logic [AW-1:0] addr);
    s2_address    = addr;
    s2_chipselect = 1'b1;
    s2_read       = 1'b1;
    cycle();
    idle();
    repeat (LAT - 1) cycle();
  endtask

  logic [DW-1:0] heldData;
  logic          heldValid;
  logic [DW-1:0] got[$];

  initial begin
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    s1_address = '0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    idle();
    repeat (2) cycle();
    checkOutput("reset_s1_data",  s1_readdata, 32'h0);
    checkOutput("reset_s1_valid", 32'(s1_readdatavalid), 32'h0);
    checkOutput("reset_s2_data",  s2_readdata, 32'h0);
    checkOutput("reset_s2_valid", 32'(s2_readdatavalid), 32'h0);
    checkOutput("reset_range",    32'(range_err), 32'h0);
    reset = 1'b0;
    cycle();

    applyStimulus(16'h0010, 32'hDEADBEEF, 4'hF);
    readS1(16'h0010);
    checkOutput("t1_s1_valid", 32'(s1_readdatavalid), 32'h1);
    checkOutput("t1_s1_data",  s1_readdata, 32'hDEADBEEF);
    cycle();
    checkOutput("t1_valid_pulse", 32'(s1_readdatavalid), 32'h0);
    checkOutput("t1_data_held",   s1_readdata, 32'hDEADBEEF);

    applyStimulus(16'd5, 32'h11223344, 4'hF);
    applyStimulus(16'd5, 32'hAABBCCDD, 4'b0101);
    readS2(16'd5);
    checkOutput("t2_s2_valid", 32'(s2_readdatavalid), 32'h1);
    checkOutput("t2_s2_data",  s2_readdata, 32'h11BB33DD);

    applyStimulus(16'd7, 32'h0, 4'hF);
    s1_address = 16'd7; s1_read = 1'b1;
    s2_address = 16'd7; s2_writedata = 32'h12345678; s2_byteenable = 4'b0011;
    s2_chipselect = 1'b1; s2_write = 1'b1;
    cycle();
    idle();
    repeat (LAT - 1) cycle();
    checkOutput("t3_collide_valid", 32'(s1_readdatavalid), 32'h1);
    checkOutput("t3_collide_data",  s1_readdata, 32'h00005678);
    readS2(16'd7);
    checkOutput("t3_ram_after", s2_readdata, 32'h00005678);

    applyStimulus(16'd39999, 32'hCAFEF00D, 4'hF);
    checkOutput("t4_edge_write_noerr", 32'(range_err), 32'h0);
    applyStimulus(16'd40000, 32'hFFFFFFFF, 4'hF);
    checkOutput("t4_oor_write_err", 32'(range_err), 32'h1);
    cycle();
    checkOutput("t4_oor_write_pulse", 32'(range_err), 32'h0);
    readS2(16'd40000);
    checkOutput("t4_oor_read_valid", 32'(s2_readdatavalid), 32'h1);
    checkOutput("t4_oor_read_data",  s2_readdata, 32'h0);
    checkOutput("t4_oor_read_err",   32'(range_err), 32'h1);
    readS2(16'd39999);
    checkOutput("t4_edge_read_data", s2_readdata, 32'hCAFEF00D);
    checkOutput("t4_edge_read_noerr", 32'(range_err), 32'h0);
    s1_address = 16'd50000; s1_read = 1'b1;
    s2_address = 16'd60000; s2_chipselect = 1'b1; s2_read = 1'b1;
    cycle();
    idle();
    repeat (LAT - 1) cycle();
    checkOutput("t4_both_oor_err", 32'(range_err), 32'h1);
    checkOutput("t4_both_oor_s1",  s1_readdata, 32'h0);
    cycle();
    checkOutput("t4_both_oor_single", 32'(range_err), 32'h0);

    reset_req = 1'b1;
    applyStimulus(16'h0010, 32'h01010101, 4'hF);
    reset_req = 1'b0;
    readS1(16'h0010);
    checkOutput("rreq_write_blocked", s1_readdata, 32'hDEADBEEF);

    for (int a = 0; a < 4; a++) applyStimulus(AW'(a), 32'hA0 + 32'(a), 4'hF);
    cycle();
    heldData  = s1_readdata;
    heldValid = s1_readdatavalid;
    for (int step = 0; step < 8; step++) begin
      clken      = !(step == 2 || step == 3);
      s1_read    = (step < 6);
      s1_address = (step < 2) ? AW'(step) : (step < 5 ? AW'(2) : AW'(3));
      cycle();
      if (clken) begin
        if (s1_readdatavalid) got.push_back(s1_readdata);
      end else begin
        checkOutput("t5_frozen_data",  s1_readdata, heldData);
        checkOutput("t5_frozen_valid", 32'(s1_readdatavalid), 32'(heldValid));
      end
      heldData  = s1_readdata;
      heldValid = s1_readdatavalid;
    end
    clken = 1'b1;
    idle();
    checkOutput("t5_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) checkOutput("t5_order", got[k], 32'hA0 + 32'(k));
    end

    applyStimulus(16'd20, 32'h55AA55AA, 4'hF);
    readS1(16'h0010);
    s1_address = 16'd20; s1_read = 1'b1;
    reset = 1'b1;
    cycle();
    idle();
    reset = 1'b0;
    checkOutput("t6_reset_valid", 32'(s1_readdatavalid), 32'h0);
    checkOutput("t6_reset_data",  s1_readdata, 32'h0);
    cycle();
    checkOutput("t6_no_late_valid", 32'(s1_readdatavalid), 32'h0);
    readS1(16'd20);
    checkOutput("t6_ram_kept", s1_readdata, 32'h55AA55AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
